// File: rtl/exc_ctrl_if.sv
// Bundle between the MEM stage / CP0 and the exception controller.
// The pipeline side is the master; the controller is the slave.
interface exc_ctrl_if;
    logic        i_cache_stall;
    logic        inst_valid_i;
    logic [31:0] pc_i;
    logic        is_in_delayslot_i;
    logic [31:0] data_addr_i;
    logic        adel_if_i;
    logic        ri_i;
    logic        ov_i;
    logic        trap_i;
    logic        syscall_i;
    logic        break_i;
    logic        adel_d_i;
    logic        ades_i;
    logic        eret_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [31:0] cp0_wdata_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport master (
        output i_cache_stall, inst_valid_i, pc_i, is_in_delayslot_i, data_addr_i,
               adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_d_i, ades_i,
               eret_i, cp0_we_i, cp0_waddr_i, cp0_wdata_i, status_i, cause_i, epc_i,
        input  excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
               flush_o, new_pc_o
    );

    modport slave (
        input  i_cache_stall, inst_valid_i, pc_i, is_in_delayslot_i, data_addr_i,
               adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_d_i, ades_i,
               eret_i, cp0_we_i, cp0_waddr_i, cp0_wdata_i, status_i, cause_i, epc_i,
        output excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
               flush_o, new_pc_o
    );
endinterface

// File: rtl/exc_ctrl.sv
// MEM-stage exception controller: prioritises exception flags, presents the
// winner to CP0 with a flush/redirect, and holds it until CP0 accepts it.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter logic [4:0]  CP0_EPC_ADDR = 5'd14
) (
    input logic        clk,
    input logic        rst,
    exc_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] excepttype_q, excepttype_d;
    logic [31:0] current_inst_addr_q, current_inst_addr_d;
    logic        is_in_delayslot_q, is_in_delayslot_d;
    logic [31:0] bad_addr_q, bad_addr_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;

    logic        int_pend;
    logic [31:0] det_code;
    logic [31:0] det_bad;
    logic        epc_fwd;
    logic [31:0] det_new_pc;

    logic        unused_ok;
    assign unused_ok = ^{bus.status_i[31:16], bus.status_i[7:2],
                         bus.cause_i[31:16], bus.cause_i[7:0]};

    assign int_pend = bus.status_i[0] & ~bus.status_i[1]
                    & (|(bus.cause_i[15:8] & bus.status_i[15:8]));

    // Fixed priority: first flag that matches wins, zero code means nothing to take.
    always_comb begin
        det_code = 32'h0;
        det_bad  = 32'h0;
        if (int_pend)               det_code = 32'h1;
        else if (bus.adel_if_i) begin
            det_code = 32'h4;
            det_bad  = bus.pc_i;
        end
        else if (bus.ri_i)          det_code = 32'hA;
        else if (bus.ov_i)          det_code = 32'hC;
        else if (bus.trap_i)        det_code = 32'hD;
        else if (bus.syscall_i)     det_code = 32'h8;
        else if (bus.break_i)       det_code = 32'h9;
        else if (bus.adel_d_i) begin
            det_code = 32'h4;
            det_bad  = bus.data_addr_i;
        end
        else if (bus.ades_i) begin
            det_code = 32'h5;
            det_bad  = bus.data_addr_i;
        end
        else if (bus.eret_i)        det_code = 32'hE;
    end

    // An mtc0 to EPC in the same cycle as eret has not reached CP0 yet, so take its data.
    assign epc_fwd    = bus.cp0_we_i && (bus.cp0_waddr_i == CP0_EPC_ADDR);
    assign det_new_pc = (det_code == 32'hE) ? (epc_fwd ? bus.cp0_wdata_i : bus.epc_i)
                                            : EXC_VECTOR;

    always_comb begin
        state_d             = state_q;
        excepttype_d        = excepttype_q;
        current_inst_addr_d = current_inst_addr_q;
        is_in_delayslot_d   = is_in_delayslot_q;
        bad_addr_d          = bad_addr_q;
        flush_d             = flush_q;
        new_pc_d            = new_pc_q;
        case (state_q)
            IDLE: begin
                if (bus.inst_valid_i && (det_code != 32'h0)) begin
                    excepttype_d        = det_code;
                    current_inst_addr_d = bus.pc_i;
                    is_in_delayslot_d   = bus.is_in_delayslot_i;
                    bad_addr_d          = det_bad;
                    flush_d             = 1'b1;
                    new_pc_d            = det_new_pc;
                    state_d             = COMMIT;
                end
            end
            COMMIT: begin
                if (!bus.i_cache_stall) begin
                    excepttype_d = 32'h0;
                    flush_d      = 1'b0;
                    new_pc_d     = 32'h0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= IDLE;
            excepttype_q        <= 32'h0;
            current_inst_addr_q <= 32'h0;
            is_in_delayslot_q   <= 1'b0;
            bad_addr_q          <= 32'h0;
            flush_q             <= 1'b0;
            new_pc_q            <= 32'h0;
        end else begin
            state_q             <= state_d;
            excepttype_q        <= excepttype_d;
            current_inst_addr_q <= current_inst_addr_d;
            is_in_delayslot_q   <= is_in_delayslot_d;
            bad_addr_q          <= bad_addr_d;
            flush_q             <= flush_d;
            new_pc_q            <= new_pc_d;
        end
    end

    assign bus.excepttype_o        = excepttype_q;
    assign bus.current_inst_addr_o = current_inst_addr_q;
    assign bus.is_in_delayslot_o   = is_in_delayslot_q;
    assign bus.bad_addr_o          = bad_addr_q;
    assign bus.flush_o             = flush_q;
    assign bus.new_pc_o            = new_pc_q;
endmodule

// File: tb/tb_exc_ctrl.sv
// Randomised + directed bench for exc_ctrl; expected outputs are queued per
// cycle by a reference model and compared by an independent monitor.
module tb_exc_ctrl;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        valid;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] daddr;
        logic [9:0]  flags;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
    } stim_t;

    typedef struct {
        int unsigned cyc;
        logic [31:0] code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic        flush;
        logic [31:0] new_pc;
    } exp_t;

    // flag bit order: adel_if, ri, ov, trap, syscall, break, adel_d, ades, eret, (9 unused)
    localparam int F_ADEL_IF = 0, F_RI = 1, F_OV = 2, F_TRAP = 3, F_SYS = 4,
                   F_BRK = 5, F_ADEL_D = 6, F_ADES = 7, F_ERET = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    bit   m_busy = 0;
    exp_t m_out = '{cyc: 0, code: 0, pc: 0, ds: 0, bad: 0, flush: 0, new_pc: 0};

    exc_ctrl_if bus ();

    exc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{rst: 0, stall: 0, valid: 1, pc: 32'h0, ds: 0, daddr: 32'h0, flags: '0,
              we: 0, waddr: 5'd0, wdata: 32'h0, status: 32'h0, cause: 32'h0, epc: 32'h0};
        return s;
    endfunction

    // Reference model: what the outputs should be after the edge that consumes s.
    task automatic model_step(input stim_t s);
        logic [31:0] codes [10];
        bit          hits  [10];
        bit          int_pend;
        int          win;
        codes = '{32'h1, 32'h4, 32'hA, 32'hC, 32'hD, 32'h8, 32'h9, 32'h4, 32'h5, 32'hE};
        int_pend = s.status[0] && !s.status[1] && ((s.cause[15:8] & s.status[15:8]) != 8'h0);
        hits[0] = int_pend;
        for (int i = 0; i < 9; i++) hits[i+1] = s.flags[i];
        if (s.rst) begin
            m_busy = 0;
            m_out = '{cyc: 0, code: 0, pc: 0, ds: 0, bad: 0, flush: 0, new_pc: 0};
        end else if (m_busy) begin
            if (!s.stall) begin
                m_busy = 0;
                m_out.code = 0;
                m_out.flush = 0;
                m_out.new_pc = 0;
            end
        end else if (s.valid) begin
            win = -1;
            for (int i = 0; i < 10; i++) if (win < 0 && hits[i]) win = i;
            if (win >= 0) begin
                m_busy = 1;
                m_out.code  = codes[win];
                m_out.pc    = s.pc;
                m_out.ds    = s.ds;
                m_out.flush = 1;
                m_out.bad   = (win == 1) ? s.pc : ((win == 7 || win == 8) ? s.daddr : 32'h0);
                if (codes[win] == 32'hE)
                    m_out.new_pc = (s.we && s.waddr == 5'd14) ? s.wdata : s.epc;
                else
                    m_out.new_pc = EXC_VECTOR;
            end
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        exp_t e;
        rst                   = s.rst;
        bus.i_cache_stall     = s.stall;
        bus.inst_valid_i      = s.valid;
        bus.pc_i              = s.pc;
        bus.is_in_delayslot_i = s.ds;
        bus.data_addr_i       = s.daddr;
        bus.adel_if_i         = s.flags[F_ADEL_IF];
        bus.ri_i              = s.flags[F_RI];
        bus.ov_i              = s.flags[F_OV];
        bus.trap_i            = s.flags[F_TRAP];
        bus.syscall_i         = s.flags[F_SYS];
        bus.break_i           = s.flags[F_BRK];
        bus.adel_d_i          = s.flags[F_ADEL_D];
        bus.ades_i            = s.flags[F_ADES];
        bus.eret_i            = s.flags[F_ERET];
        bus.cp0_we_i          = s.we;
        bus.cp0_waddr_i       = s.waddr;
        bus.cp0_wdata_i       = s.wdata;
        bus.status_i          = s.status;
        bus.cause_i           = s.cause;
        bus.epc_i             = s.epc;
        model_step(s);
        e = m_out;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (bus.excepttype_o !== e.code || bus.current_inst_addr_o !== e.pc ||
            bus.is_in_delayslot_o !== e.ds || bus.bad_addr_o !== e.bad ||
            bus.flush_o !== e.flush || bus.new_pc_o !== e.new_pc) begin
            errors++;
            $display("[TB] FAIL outputs@cyc%0d got code=%h pc=%h ds=%b bad=%h flush=%b npc=%h expected code=%h pc=%h ds=%b bad=%h flush=%b npc=%h",
                     e.cyc, bus.excepttype_o, bus.current_inst_addr_o, bus.is_in_delayslot_o,
                     bus.bad_addr_o, bus.flush_o, bus.new_pc_o,
                     e.code, e.pc, e.ds, e.bad, e.flush, e.new_pc);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) checkOutput(exp_q.pop_front());
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired, got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        stim_t s;
        s = idle_stim();
        rst = 1'b1;
        @(posedge clk);
        #1;
        s.rst = 1; applyStimulus(s); applyStimulus(s);

        // syscall then release
        s = idle_stim(); s.flags[F_SYS] = 1; s.pc = 32'hBFC00100; applyStimulus(s);
        s = idle_stim(); applyStimulus(s); applyStimulus(s);

        // ri beats ov, delay slot flag
        s = idle_stim(); s.flags[F_RI] = 1; s.flags[F_OV] = 1; s.ds = 1; s.pc = 32'h80000040;
        applyStimulus(s);
        s = idle_stim(); applyStimulus(s);

        // interrupt beats store error, then masked by EXL
        s = idle_stim(); s.status = 32'h0000FF01; s.cause = 32'h00000200;
        s.flags[F_ADES] = 1; s.daddr = 32'h80002003; s.pc = 32'h80000100;
        applyStimulus(s);
        s = idle_stim(); applyStimulus(s);
        s = idle_stim(); s.status = 32'h0000FF03; s.cause = 32'h00000200;
        s.flags[F_ADES] = 1; s.daddr = 32'h80002003; s.pc = 32'h80000104;
        applyStimulus(s);
        s = idle_stim(); applyStimulus(s);

        // load error held through a 3-cycle stall
        s = idle_stim(); s.flags[F_ADEL_D] = 1; s.daddr = 32'h80001002; s.pc = 32'h80000200;
        applyStimulus(s);
        s = idle_stim(); s.stall = 1; s.flags[F_SYS] = 1;
        applyStimulus(s); applyStimulus(s); applyStimulus(s);
        s = idle_stim(); applyStimulus(s); applyStimulus(s);

        // eret with EPC forwarding, then with mtc0 to another register
        s = idle_stim(); s.flags[F_ERET] = 1; s.we = 1; s.waddr = 5'd14;
        s.wdata = 32'hBFC01234; s.epc = 32'h0; applyStimulus(s);
        s = idle_stim(); applyStimulus(s);
        s = idle_stim(); s.flags[F_ERET] = 1; s.we = 1; s.waddr = 5'd12;
        s.wdata = 32'hBFC01234; s.epc = 32'h80004000; applyStimulus(s);
        s = idle_stim(); applyStimulus(s);

        // bubble suppresses everything, including interrupts
        s = idle_stim(); s.valid = 0; s.flags[F_SYS] = 1; s.status = 32'h0000FF01;
        s.cause = 32'h0000FF00; applyStimulus(s);

        // reset while stalled in commit
        s = idle_stim(); s.flags[F_BRK] = 1; s.pc = 32'h80000300; applyStimulus(s);
        s = idle_stim(); s.stall = 1; applyStimulus(s);
        s.rst = 1; applyStimulus(s);
        s = idle_stim(); applyStimulus(s);

        for (int n = 0; n < 600; n++) begin
            s = idle_stim();
            s.rst    = ($urandom_range(0, 39) == 0);
            s.stall  = ($urandom_range(0, 2) == 0);
            s.valid  = ($urandom_range(0, 7) != 0);
            s.pc     = $urandom;
            s.ds     = $urandom_range(0, 1);
            s.daddr  = $urandom;
            for (int f = 0; f < 9; f++) s.flags[f] = ($urandom_range(0, 9) == 0);
            s.we     = $urandom_range(0, 1);
            s.waddr  = ($urandom_range(0, 1) == 0) ? 5'd14 : 5'($urandom);
            s.wdata  = $urandom;
            s.status = $urandom;
            s.cause  = $urandom;
            s.epc    = $urandom;
            applyStimulus(s);
        end

        s = idle_stim();
        applyStimulus(s);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
